// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell (two half adders plus an OR) walks WIDTH bits, one per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub port for a-b with a no-borrow carry.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);
    // One extra bit so the counter can reach WIDTH-1 without wrapping, even for WIDTH=1.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             b_bit, s0, c0, cell_s, c1, cell_c;
    logic [WIDTH:0]   sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;
    assign b_bit = b_sh_q[0] ^ sub_q;
`else
    assign b_bit = b_sh_q[0];
`endif

    half_adder u_ha0 (.x(a_sh_q[0]), .y(b_bit), .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(cy_q), .s(cell_s), .c(c1));
    assign cell_c = c0 | c1;

    // New sum bit enters at the MSB; the wide temp keeps the slice legal when WIDTH=1.
    assign sum_shift = {cell_s, sum_sh_q};

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d    = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    cnt_d  = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d  = sub;
                    cy_d   = sub;
`else
                    cy_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sh_d = sum_shift[WIDTH:1];
                cy_d     = cell_c;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = sum_shift[WIDTH:1];
                    carry_d = cell_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner-case sequences, random ops vs arithmetic model.

module tb_serial_adder_ctrl;
    localparam int W = 8;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         sub;
    logic [W-1:0] sum;
    logic         carry, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, carry is the bit above the result (no-borrow for subtraction).
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] rs, output logic rc);
        int unsigned full;
        if (ms) begin
            full = int'(ma) + ((1 << W) - 1 - int'(mb)) + 1;
        end else begin
            full = int'(ma) + int'(mb);
        end
        rs = full[W-1:0];
        rc = full[W];
    endtask

    // Drives one request (called just after an edge, DUT idle); returns latency, busy cycles and results.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                         output int lat, output int busy_cnt,
                         output logic [W-1:0] rs, output logic rc);
        lat = -1;
        busy_cnt = 0;
        start = 1'b1;
        a = oa;
        b = ob;
        sub = os;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = HAS_SUB ? 1'($urandom) : 1'b0;
        if (busy) busy_cnt++;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        rs = sum;
        rc = carry;
        @(posedge clk);
        #1;
        check("done_falls", 32'(done), 32'd0);
        check("busy_falls", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, bc, ndone;
        logic [W-1:0] rs, es;
        logic rc, ec, rsub;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        #12;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector table
        vecs.push_back('{va: 3,   vb: 5,   vsub: 0, exp_sum: 8,   exp_carry: 0});
        vecs.push_back('{va: 255, vb: 1,   vsub: 0, exp_sum: 0,   exp_carry: 1});
        vecs.push_back('{va: 255, vb: 255, vsub: 0, exp_sum: 254, exp_carry: 1});
        vecs.push_back('{va: 0,   vb: 0,   vsub: 0, exp_sum: 0,   exp_carry: 0});
        vecs.push_back('{va: 128, vb: 128, vsub: 0, exp_sum: 0,   exp_carry: 1});
        vecs.push_back('{va: 170, vb: 85,  vsub: 0, exp_sum: 255, exp_carry: 0});
        if (HAS_SUB) begin
            vecs.push_back('{va: 5, vb: 3, vsub: 1, exp_sum: 2,   exp_carry: 1});
            vecs.push_back('{va: 3, vb: 5, vsub: 1, exp_sum: 254, exp_carry: 0});
            vecs.push_back('{va: 9, vb: 9, vsub: 1, exp_sum: 0,   exp_carry: 1});
        end
        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, lat, bc, rs, rc);
            check("vec_latency", 32'(lat), 32'd8);
            check("vec_busy_cycles", 32'(bc), 32'd9);
            check("vec_sum", 32'(rs), 32'(vecs[i].exp_sum));
            check("vec_carry", 32'(rc), 32'(vecs[i].exp_carry));
        end

        // start during RUN and DONE is ignored
        start = 1'b1;
        a = 1;
        b = 1;
        sub = 1'b0;
        @(posedge clk);
        #1;
        a = 100;
        b = 100;
        ndone = 0;
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        start = 1'b0;
        check("ign_sum", 32'(sum), 32'd2);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_idle", 32'(busy), 32'd0);
        check("ign_sum_hold", 32'(sum), 32'd2);

        // reset in the 4th RUN cycle aborts the operation
        start = 1'b1;
        a = 200;
        b = 100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_carry", 32'(carry), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
        do_op(7, 9, 1'b0, lat, bc, rs, rc);
        check("post_rst_sum", 32'(rs), 32'd16);
        check("post_rst_lat", 32'(lat), 32'd8);

        // start held high: one operation per W+2 cycles
        start = 1'b1;
        a = 10;
        b = 20;
        @(posedge clk);
        #1;
        for (int k = 1; k < 30; k++) begin
            @(posedge clk);
            #1;
            check("held_done", 32'(done), 32'((k == 8) || (k == 18) || (k == 28)));
            if (done) check("held_sum", 32'(sum), 32'd30);
        end
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;

        // randomized operations
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rsub = HAS_SUB ? 1'($urandom) : 1'b0;
            if (i == 0) begin
                ra = 255;
                rb = 0;
            end
            model(ra, rb, rsub, es, ec);
            do_op(ra, rb, rsub, lat, bc, rs, rc);
            check("rand_lat", 32'(lat), 32'd8);
            check("rand_sum", 32'(rs), 32'(es));
            check("rand_carry", 32'(rc), 32'(ec));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that shares a single 1-bit full-adder cell, built from two `half_adder` instances plus an OR gate, across all bit positions of a WIDTH-bit operand pair. It accepts a start request, loads the operands, and sequences one bit per clock through the shared cell. It then presents the registered result with a one-cycle done pulse. It sits between a requesting control unit and the adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 1..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `sub`  in  1  subtract select; port present only when `SERIAL_ADDER_SUB_EN` is defined.
- `sum`  out  WIDTH  registered result.
- `carry`  out  1  registered final carry-out.
- `busy`  out  1  high while an operation is in flight, from RUN through DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE, with `start`=1 at an edge:
  - load `a` and `b` into right-shift registers;
  - clear the bit counter;
  - set the carry flop to 0, or to `sub` when subtraction is enabled;
  - go to RUN.
- RUN, each edge:
  - the cell inputs are a_sh[0], b_sh[0] (or ~b_sh[0] when sub is latched) and the carry flop;
  - the cell sum bit shifts into the MSB of the sum shift register;
  - the cell carry updates the carry flop;
  - a_sh and b_sh shift right;
  - the counter increments.
- RUN exit: on the edge that processes bit WIDTH-1, load `sum` from the completed shift value and `carry` from the final cell carry, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE; the request is not queued.
- `a`, `b` and `sub` are don't-care outside the accepting edge.
- `sum` and `carry` hold their last result until the next completion. Intermediate bits are never visible on `sum`.
- Arithmetic is modulo 2^WIDTH. `carry` is the true carry-out of bit WIDTH-1.
- Counter width is clog2(WIDTH)+1, so it does not wrap before the compare.

## Timing
- Reset, asynchronous: state=IDLE; `sum`=0, `carry`=0, `busy`=0, `done`=0; shift registers, counter and carry flop all 0.
- Reset mid-operation: the operation is aborted, no `done` pulse is issued, and `sum`/`carry` return to 0.
- Let E0 be the edge that accepts `start`.
  - `busy`=1 from E0 onward.
  - The RUN edges are E1..E_WIDTH.
  - `done`=1 and `sum`/`carry` are valid after edge E_WIDTH.
  - After E_WIDTH+1: `done`=0, `busy`=0, state IDLE.
- Latency is WIDTH cycles from acceptance to done.
- The earliest next acceptance is edge E_WIDTH+2. If `start` is held high continuously, throughput is one operation per WIDTH+2 cycles.
- WIDTH=1: a single RUN cycle; `done` follows E1.
- `done` and `busy` are both high in the DONE cycle, and both fall together.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - the `sub` port exists and is latched at E0;
  - with `sub`=1, B is inverted per bit and carry-in is 1, computing a−b mod 2^WIDTH;
  - `carry` then means no-borrow: 1 when a ≥ b unsigned.
- Not defined: no `sub` port, carry-in is always 0, and the block is addition only.

## Test plan
- WIDTH=8, a=3, b=5, pulse `start` -> `done` high exactly 8 cycles after E0; `sum`=8, `carry`=0; `busy` high for 9 cycles.
- a=255, b=1 -> `sum`=0, `carry`=1. Then a=255, b=255 -> `sum`=254, `carry`=1.
- Pulse `start` with a=1, b=1, then assert `start` with a=100, b=100 during RUN and during DONE -> exactly one `done`, `sum`=2; the second request is not executed.
- Assert `rst` at the 4th RUN cycle of a=200, b=100 -> all outputs 0 immediately. No `done` follows. A subsequent start with a=7, b=9 gives `sum`=16.
- Hold `start`=1 for 30 cycles with a=10, b=20 -> `done` pulses at E0+8, E0+18 and E0+28; `sum`=30 each time.
- With `SERIAL_ADDER_SUB_EN`: sub=1, a=5, b=3 -> `sum`=2, `carry`=1. sub=1, a=3, b=5 -> `sum`=254, `carry`=0.
